// File: rtl/rsa_decrypt_core.sv
// RSA decryption core: plain_out = cipher_in ^ d_in mod n_in.
// Constant-time right-to-left square-and-multiply over a bit-serial Blakley multiplier.
module rsa_decrypt_core #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] cipher_in,
   input  logic [W-1:0] d_in,
   input  logic [W-1:0] n_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] plain_out,
   output logic         err
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PRE,
      S_MUL_R,
      S_MUL_B,
      S_FINISH
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]  n_q, n_d;
   logic [W-1:0]  e_q, e_d;
   logic [W-1:0]  op_a_q, op_a_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  base_q, base_d;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  plain_q, plain_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] bit_q, bit_d;
   logic          bad_q, bad_d;
   logic          err_q, err_d;
   logic          done_q, done_d;

   logic [W-1:0]  op_b;
   logic [W:0]    n_ext;
   logic [W:0]    dbl;
   logic [W-1:0]  dbl_r;
   logic [W:0]    sum;
   logic [W-1:0]  step;
   logic          cnt_last;
   logic          bit_last;

   // One Blakley step: acc = 2*acc mod n, then add b mod n when the a bit is set.
   always_comb begin
      op_b  = (state_q == S_PRE) ? W'(1) : base_q;
      n_ext = {1'b0, n_q};
      dbl   = {acc_q, 1'b0};
      dbl_r = (dbl >= n_ext) ? W'(dbl - n_ext) : W'(dbl);
      sum   = {1'b0, dbl_r} + {1'b0, op_b};
      if (op_a_q[W-1]) begin
         step = (sum >= n_ext) ? W'(sum - n_ext) : W'(sum);
      end else begin
         step = dbl_r;
      end
   end

   assign cnt_last = (cnt_q == CW'(W - 1));
   assign bit_last = (bit_q == CW'(W - 1));

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      e_d     = e_q;
      op_a_d  = op_a_q;
      acc_d   = acc_q;
      base_d  = base_q;
      res_d   = res_q;
      plain_d = plain_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      bad_d   = bad_q;
      err_d   = err_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = n_in;
               e_d     = d_in;
               op_a_d  = cipher_in;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            err_d = 1'b0;
            cnt_d = '0;
            bit_d = '0;
            acc_d = '0;
            if (n_q < W'(2)) begin
               bad_d   = 1'b1;
               res_d   = '0;
               state_d = S_FINISH;
            end else begin
               bad_d   = 1'b0;
               res_d   = W'(1);
               state_d = S_PRE;
            end
         end

         S_PRE: begin
            acc_d  = step;
            op_a_d = op_a_q << 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_last) begin
               base_d  = step;
               op_a_d  = res_q;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_MUL_R;
            end
         end

         S_MUL_R: begin
            acc_d  = step;
            op_a_d = op_a_q << 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_last) begin
               if (e_q[0]) begin
                  res_d = step;
               end
               op_a_d  = base_q;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_MUL_B;
            end
         end

         S_MUL_B: begin
            acc_d  = step;
            op_a_d = op_a_q << 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_last) begin
               base_d = step;
               e_d    = e_q >> 1;
               bit_d  = bit_q + CW'(1);
               op_a_d = res_q;
               acc_d  = '0;
               cnt_d  = '0;
               if (bit_last) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_MUL_R;
               end
            end
         end

         S_FINISH: begin
            plain_d = res_q;
            err_d   = bad_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         e_q     <= '0;
         op_a_q  <= '0;
         acc_q   <= '0;
         base_q  <= '0;
         res_q   <= '0;
         plain_q <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         e_q     <= e_d;
         op_a_q  <= op_a_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         res_q   <= res_d;
         plain_q <= plain_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign plain_out = plain_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Scoreboard bench for rsa_decrypt_core (W=8).
// Expected results are queued at start and checked when done pulses.
module tb_rsa_decrypt_core;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] cipher_in;
   logic [7:0] d_in;
   logic [7:0] n_in;
   logic       busy;
   logic       done;
   logic [7:0] plain_out;
   logic       err;

   typedef struct {
      logic [7:0] p;
      logic       e;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   rsa_decrypt_core #(.W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cipher_in (cipher_in),
      .d_in      (d_in),
      .n_in      (n_in),
      .busy      (busy),
      .done      (done),
      .plain_out (plain_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_pow(input int c, input int d, input int n);
      int r;
      r = 1 % n;
      for (int i = 0; i < d; i++) begin
         r = (r * c) % n;
      end
      return r;
   endfunction

   task automatic start_run(input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] n, input logic [7:0] ep,
                            input logic ee);
      exp_t x;
      x.p   = ep;
      x.e   = ee;
      x.lat = ee ? 2 : 138;
      exp_q.push_back(x);
      @(negedge clk);
      cipher_in = c;
      d_in      = d;
      n_in      = n;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start: got %b want 1", busy);
      end
   endtask

   task automatic wait_done(input bit disturb);
      int   cyc;
      bit   seen;
      exp_t x;
      cyc  = 0;
      seen = 1'b0;
      while (cyc < 400 && !seen) begin
         if (disturb && cyc == 20) begin
            cipher_in = ~cipher_in;
            d_in      = 8'h00;
            n_in      = 8'd1;
         end
         if (disturb && cyc == 50) start = 1'b1;
         if (disturb && cyc == 51) start = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
         if (done === 1'b1) seen = 1'b1;
      end
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         x = exp_q.pop_front();
         total++;
         if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no done in %0d edges want %0d", cyc, x.lat);
         end else begin
            if (cyc !== x.lat) begin
               bad++;
               $display("FAIL latency: got %0d want %0d", cyc, x.lat);
            end
            total++;
            if (plain_out !== x.p) begin
               bad++;
               $display("FAIL plain_out: got %0d want %0d", plain_out, x.p);
            end
            total++;
            if (err !== x.e) begin
               bad++;
               $display("FAIL err: got %b want %b", err, x.e);
            end
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL busy_at_done: got %b want 0", busy);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      start     = 1'b0;
      cipher_in = '0;
      d_in      = '0;
      n_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++;
      if (plain_out !== 8'd0) begin bad++; $display("FAIL reset_plain: got %0d want 0", plain_out); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_decrypt();
      start_run(8'd128, 8'd103, 8'd143, 8'd2, 1'b0);
      wait_done(1'b0);
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
      start_run(8'd48, 8'd103, 8'd143, 8'd9, 1'b0);
      wait_done(1'b0);
   endtask

   task automatic test_edge_cases();
      start_run(8'd200, 8'd1, 8'd143, 8'd57, 1'b0);
      wait_done(1'b0);
      start_run(8'd5, 8'd0, 8'd143, 8'd1, 1'b0);
      wait_done(1'b0);
      start_run(8'd0, 8'd103, 8'd143, 8'd0, 1'b0);
      wait_done(1'b0);
      start_run(8'd143, 8'd5, 8'd143, 8'd0, 1'b0);
      wait_done(1'b0);
   endtask

   task automatic test_invalid_modulus();
      start_run(8'd9, 8'd7, 8'd143, 8'd48, 1'b0);
      wait_done(1'b0);
      start_run(8'd7, 8'd3, 8'd1, 8'd0, 1'b1);
      wait_done(1'b0);
      start_run(8'd128, 8'd103, 8'd143, 8'd2, 1'b0);
      wait_done(1'b0);
   endtask

   task automatic test_protocol();
      start_run(8'd48, 8'd103, 8'd143, 8'd9, 1'b0);
      wait_done(1'b1);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL no_queued_start: got busy %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      start_run(8'd2, 8'd7, 8'd143, 8'd128, 1'b0);
      wait_done(1'b0);
      start_run(8'd9, 8'd7, 8'd143, 8'd48, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      total++;
      if (plain_out !== 8'd128) begin
         bad++;
         $display("FAIL plain_hold: got %0d want 128", plain_out);
      end
      begin
         exp_t x;
         x = exp_q.pop_front();
         x.lat = x.lat - 40;
         exp_q.push_front(x);
      end
      wait_done(1'b0);
   endtask

   task automatic test_reset_midrun();
      bit fired;
      @(negedge clk);
      cipher_in = 8'd128;
      d_in      = 8'd103;
      n_in      = 8'd143;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (59) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL midrun_reset_busy: got %b want 0", busy); end
      total++;
      if (plain_out !== 8'd0) begin bad++; $display("FAIL midrun_reset_plain: got %0d want 0", plain_out); end
      @(negedge clk);
      reset = 1'b0;
      fired = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) fired = 1'b1;
      end
      total++;
      if (fired) begin bad++; $display("FAIL midrun_reset_done: got pulse want none"); end
      start_run(8'd200, 8'd1, 8'd143, 8'd57, 1'b0);
      wait_done(1'b0);
   endtask

   task automatic test_sweep();
      for (int c = 0; c < 256; c++) begin
         start_run(8'(c), 8'd103, 8'd143, 8'(ref_pow(c, 103, 143)), 1'b0);
         wait_done(1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_decrypt();
      test_edge_cases();
      test_invalid_modulus();
      test_protocol();
      test_back_to_back();
      test_reset_midrun();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsa_decrypt_core.md
Name: rsa_decrypt_core

Overview:
- Sequential RSA decryption engine: computes plain_out = cipher_in ^ d_in mod n_in using constant-time, right-to-left square-and-multiply.
- Modular multiplication is bit-serial interleaved shift-add-subtract (Blakley), with no divider or `%` operator.
- Sits between uart_rx (received ciphertext byte) and uart_tx (recovered plaintext byte). It is the receive-side counterpart of the RSA encryptor.

Parameters:
- W, 8, operand width of cipher_in, d_in, n_in and plain_out. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- cipher_in  input  W  ciphertext C; may be >= n_in
- d_in  input  W  private exponent d
- n_in  input  W  modulus n
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse; plain_out and err are valid in that cycle
- plain_out  output  W  result M = C^d mod n; held until the next start
- err  output  1  set with done when n_in < 2; held until the next start

Behaviour:
- Reset (async, any state): FSM goes to IDLE; busy=0, done=0, plain_out=0, err=0; all internal registers cleared. A computation in progress is abandoned with no done pulse.
- Start sampling: start is sampled in IDLE only. The sampling edge latches C, d and n into internal registers; input changes after that edge have no effect. start while busy is ignored; no queueing.
- States: IDLE, CHECK, PRE, MUL_R, MUL_B, FINISH.
- IDLE: on start go to CHECK; busy=1 from the next cycle.
- CHECK (1 cycle): if n < 2, set plain_out=0, err=1, done=1, busy=0 and return to IDLE. Otherwise set err=0, res=1, and go to PRE.
- mulmod(a, b), with b < n: acc starts at 0. Over exactly W cycles, scanning a MSB first, each cycle does:
  - acc = 2*acc; if acc >= n then acc -= n
  - if the a bit is 1: acc += b; if acc >= n then acc -= n
  - acc is W+1 bits wide; there is never more than one subtraction per step.
- PRE (W cycles): base = mulmod(C, 1). This reduces C mod n, so C >= n is legal.
- Exponent loop over d bits LSB first, all W bits regardless of value (constant time):
  - MUL_R (W cycles): t = mulmod(res, base); res = t only if the current d bit is 1.
  - MUL_B (W cycles): base = mulmod(base, base).
  - Then advance the bit index. After bit W-1, go to FINISH; otherwise go to MUL_R.
- FINISH (1 cycle): plain_out=res, done=1, busy=0, go to IDLE.
- Latency: done is visible after the edge that is exactly 2 + W + 2W^2 edges after the start-sampling edge (W=8: 138). For the err path it is 2 edges.
- Results:
  - d=0 returns 1 (n >= 2).
  - C=0 with d > 0 returns 0.
  - C mod n = 0 with d > 0 returns 0.
- A start in the same cycle as done, or in the cycle after it, is honoured once the FSM is in IDLE. plain_out holds its old value until FINISH of the new run.

Test Plan:
- Decrypt a byte: n=143, d=103, C=128, start -> busy for the full run; done after 138 edges; plain_out=2, err=0.
- Second run: n=143, d=103, C=48 -> plain_out=9. Loopback check: a model computing 9^7 mod 143 gives 48 and 2^7 mod 143 gives 128.
- Exponent edge cases, all with n=143:
  - C=200, d=1 -> plain_out=57 (input reduction)
  - C=5, d=0 -> 1
  - C=0, d=103 -> 0
  - every case takes the same 138-edge latency.
- Invalid modulus: n=1, C=7, d=3 -> done 2 edges after start; err=1, plain_out=0. Next run with n=143 clears err.
- Protocol checks:
  - start pulsed mid-run -> ignored; result and latency unchanged.
  - inputs changed after start -> no effect.
  - reset asserted at edge 60 -> busy=0, done never pulses, plain_out=0; a fresh run then completes correctly.
- Random sweep: n=143, all C in 0..255, d=103 -> plain_out matches the reference model C^103 mod 143 for every C.
